payment_scheduler: RTL and testbench

- Sequences departing cars through the single payment point of the parking lot.
- Keeps per-slot day/night occupancy timers and snapshots them at departure.
- Queues simultaneous departures with a round-robin arbiter and presents one bill at a time.
- Holds each bill until payment is acknowledged or times out; sits between debounced slot switches and the display/billing views.

---
 rtl/pl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/payment_scheduler.sv | 165 ++++++++++++++++
 tb/tb_payment_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_pkg.sv
// Shared state encoding, field widths and fee saturation for the parking-lot payment scheduler.
package pl_pkg;

  localparam int DAY_W   = 6;
  localparam int NIGHT_W = 5;
  localparam int FEE_W   = 8;
  localparam int HOUR_W  = 5;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, CALC, PRESENT} state_t;

  typedef logic [DAY_W-1:0]   day_t;
  typedef logic [NIGHT_W-1:0] night_t;

  // A raw fee one bit wider than the bill field collapses to all-ones on overflow.
  function automatic logic [FEE_W-1:0] sat_fee(input logic [FEE_W:0] raw);
    return raw[FEE_W] ? '1 : raw[FEE_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves a latch behind.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/payment_scheduler.sv
// Parking-lot payment scheduler: per-slot day/night timers, departure snapshots and a
// round-robin bill presenter. Define PAYMENT_FEE_CAP_EN to clamp bill_fee at FEE_CAP.
module payment_scheduler
  import pl_pkg::*;
#(
  parameter int N_SLOTS     = 8,
  parameter int DAY_START   = 6,
  parameter int DAY_END     = 22,
  parameter int DAY_RATE    = 2,
  parameter int NIGHT_RATE  = 1,
  parameter int PAY_TIMEOUT = 30,
  parameter int FEE_CAP     = 40
) (
  input  logic                       rst,
  input  logic                       time_clk,
  input  logic                       power,
  input  logic [HOUR_W-1:0]          hour,
  input  logic [N_SLOTS-1:0]         occupied,
  input  logic [N_SLOTS-1:0]         slot_mask,
  input  logic                       pay_ack,
  output logic                       bill_valid,
  output logic [$clog2(N_SLOTS)-1:0] bill_slot,
  output logic [DAY_W-1:0]           bill_day,
  output logic [NIGHT_W-1:0]         bill_night,
  output logic [FEE_W-1:0]           bill_fee,
  output logic [N_SLOTS-1:0]         pending,
  output logic [CNT_W-1:0]           pending_cnt,
  output logic                       timeout_flag
);

  localparam int IW    = $clog2(N_SLOTS);
  localparam int TW    = $clog2(PAY_TIMEOUT + 1);
  localparam int RAW_W = FEE_W + 1;
`ifdef PAYMENT_FEE_CAP_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic [N_SLOTS-1:0] occ_eff, occ_q, dep, grant;
  day_t               day_cnt    [N_SLOTS];
  night_t             night_cnt  [N_SLOTS];
  day_t               snap_day   [N_SLOTS];
  night_t             snap_night [N_SLOTS];
  state_t             state;
  logic [IW-1:0]      sel, ptr, next_ptr, grant_idx;
  logic [TW-1:0]      tcnt;
  logic               paid, is_day;
  logic [RAW_W-1:0]   fee_raw;
  logic [FEE_W-1:0]   fee;

  assign occ_eff     = occupied & slot_mask;
  assign dep         = occ_q & ~occ_eff & ~pending;
  assign paid        = (state == PRESENT) && pay_ack;
  assign is_day      = (int'(hour) >= DAY_START) && (int'(hour) <= DAY_END);
  assign next_ptr    = (sel == IW'(N_SLOTS - 1)) ? '0 : sel + 1'b1;
  assign pending_cnt = CNT_W'($countones(pending));

  rr_arbiter #(.N(N_SLOTS), .IW(IW)) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_comb begin
    fee_raw = RAW_W'(snap_day[sel] * DAY_RATE) + RAW_W'(snap_night[sel] * NIGHT_RATE);
    fee     = sat_fee(fee_raw);
    if (CAP_EN && (int'(fee) > FEE_CAP)) fee = FEE_W'(FEE_CAP);
  end

  // Occupancy timers, departure snapshots and the pending set.
  always_ff @(posedge time_clk or negedge rst) begin
    if (!rst) begin
      occ_q   <= '0;
      pending <= '0;
      // NOTE: the timer/snapshot arrays are plain flops, so they are reset with the rest of the state.
      for (int i = 0; i < N_SLOTS; i++) begin
        day_cnt[i]  <= '0;
        night_cnt[i] <= '0;
        snap_day[i] <= '0;
        snap_night[i] <= '0;
      end
    end else if (!power) begin
      occ_q   <= '0;
      pending <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        day_cnt[i]  <= '0;
        night_cnt[i] <= '0;
        snap_day[i] <= '0;
        snap_night[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every slot sees the pre-edge timers and pending bits.
      occ_q <= occ_eff;
      for (int i = 0; i < N_SLOTS; i++) begin
        if (dep[i]) begin
          snap_day[i]   <= day_cnt[i];
          snap_night[i] <= night_cnt[i];
        end
        // A pending slot keeps its timers at zero, so a re-entering car starts fresh after payment.
        if (occ_eff[i] && !pending[i]) begin
          if (is_day) begin
            if (day_cnt[i] != '1) day_cnt[i] <= day_cnt[i] + 1'b1;
          end else begin
            if (night_cnt[i] != '1) night_cnt[i] <= night_cnt[i] + 1'b1;
          end
        end else begin
          day_cnt[i]   <= '0;
          night_cnt[i] <= '0;
        end
        pending[i] <= dep[i] | (pending[i] & ~(paid && (sel == IW'(i))));
      end
    end
  end

  // Bill presentation FSM with registered outputs.
  always_ff @(posedge time_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; sel <= '0; ptr <= '0; tcnt <= '0;
      bill_valid <= 1'b0; bill_slot <= '0; bill_day <= '0; bill_night <= '0;
      bill_fee <= '0; timeout_flag <= 1'b0;
    end else if (!power) begin
      state <= IDLE; sel <= '0; ptr <= '0; tcnt <= '0;
      bill_valid <= 1'b0; bill_slot <= '0; bill_day <= '0; bill_night <= '0;
      bill_fee <= '0; timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|grant) begin
            sel   <= grant_idx;
            state <= CALC;
          end
        end
        CALC: begin
          bill_slot  <= sel;
          bill_day   <= snap_day[sel];
          bill_night <= snap_night[sel];
          bill_fee   <= fee;
          bill_valid <= 1'b1;
          tcnt       <= '0;
          state      <= PRESENT;
        end
        PRESENT: begin
          if (pay_ack) begin
            bill_valid <= 1'b0;
            ptr        <= next_ptr;
            state      <= IDLE;
          end else if (tcnt == TW'(PAY_TIMEOUT - 1)) begin
            // Unpaid slot stays pending and is re-billed when the pointer comes round again.
            timeout_flag <= 1'b1;
            bill_valid   <= 1'b0;
            ptr          <= next_ptr;
            state        <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payment_scheduler.sv
// Scoreboard bench for payment_scheduler: a slot-level occupancy/billing model predicts
// every bill; a negedge monitor pops and compares each presented bill.
module tb_payment_scheduler;

  localparam int N          = 8;
  localparam int DAY_START  = 6;
  localparam int DAY_END    = 22;
  localparam int DAY_RATE   = 2;
  localparam int NIGHT_RATE = 1;
  localparam int TIMEOUT    = 30;
  localparam int CAP        = 40;

  logic       rst = 1'b0, time_clk = 1'b0, power = 1'b0, pay_ack = 1'b0;
  logic [4:0] hour = '0;
  logic [7:0] occupied = '0, slot_mask = 8'hFF;
  logic       bill_valid, timeout_flag;
  logic [2:0] bill_slot;
  logic [5:0] bill_day;
  logic [4:0] bill_night;
  logic [7:0] bill_fee, pending;
  logic [3:0] pending_cnt;

  payment_scheduler dut (
    .rst(rst), .time_clk(time_clk), .power(power), .hour(hour),
    .occupied(occupied), .slot_mask(slot_mask), .pay_ack(pay_ack),
    .bill_valid(bill_valid), .bill_slot(bill_slot), .bill_day(bill_day),
    .bill_night(bill_night), .bill_fee(bill_fee), .pending(pending),
    .pending_cnt(pending_cnt), .timeout_flag(timeout_flag)
  );

  always #5 time_clk = ~time_clk;

  typedef struct { int slot; int day; int night; int fee; int cnt; } bill_t;
  bill_t exp_q[$];
  bit    dec_q[$];
  int    total = 0, bad = 0;

  // Reference model: per-slot stay counters, snapshots, pending set, round-robin pointer.
  int         m_day[N], m_night[N], snap_d[N], snap_n[N];
  logic [7:0] mpend, m_eff_q;
  int         m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int fee_of(input int d, input int n);
    int f;
    f = d * DAY_RATE + n * NIGHT_RATE;
    if (f > 255) f = 255;
`ifdef PAYMENT_FEE_CAP_EN
    if (f > CAP) f = CAP;
`endif
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_day[i] = 0; m_night[i] = 0; snap_d[i] = 0; snap_n[i] = 0;
    end
    mpend = '0; m_eff_q = '0; m_ptr = 0;
  endtask

  task automatic step();
    @(posedge time_clk);
    #1;
  endtask

  // Apply one cycle of occupancy/hour and advance the model by one time tick.
  task automatic cycle(input logic [7:0] occ, input int hr);
    logic [7:0] eff;
    occupied = occ;
    hour     = 5'(hr);
    eff      = occ & slot_mask;
    step();
    if (!power) begin
      model_clear();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (!mpend[i]) begin
        if (eff[i]) begin
          if (hr >= DAY_START && hr <= DAY_END) m_day[i] = (m_day[i] < 63) ? m_day[i] + 1 : 63;
          else m_night[i] = (m_night[i] < 31) ? m_night[i] + 1 : 31;
        end else begin
          if (m_eff_q[i]) begin
            snap_d[i] = m_day[i]; snap_n[i] = m_night[i]; mpend[i] = 1'b1;
          end
          m_day[i] = 0; m_night[i] = 0;
        end
      end
    end
    m_eff_q = eff;
  endtask

  // mode 0: pay every bill; 1: random timeouts (once per slot); 2: first bill times out.
  task automatic plan_bills(input int mode);
    logic [7:0] pend;
    int         ptr, s;
    bit         to, first;
    bit         timed[N];
    pend = mpend; ptr = m_ptr; first = 1'b1;
    for (int i = 0; i < N; i++) timed[i] = 1'b0;
    while (pend != 0) begin
      s = -1;
      for (int k = 0; k < N; k++) if (s < 0 && pend[(ptr + k) % N]) s = (ptr + k) % N;
      exp_q.push_back('{s, snap_d[s], snap_n[s], fee_of(snap_d[s], snap_n[s]), $countones(pend)});
      case (mode)
        1:       to = !timed[s] && ($urandom_range(0, 3) == 0);
        2:       to = first;
        default: to = 1'b0;
      endcase
      first = 1'b0;
      if (to) timed[s] = 1'b1;
      else    pend[s] = 1'b0;
      dec_q.push_back(to);
      ptr = (s + 1) % N;
    end
    mpend = '0;
    m_ptr = ptr;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!bill_valid && n < 50) begin step(); n++; end
    ok = bill_valid;
  endtask

  task automatic serve_bills();
    bit ok, to;
    int n;
    while (dec_q.size() > 0) begin
      to = dec_q.pop_front();
      wait_valid(ok);
      check("bill_arrives", ok, 1);
      if (!ok) begin
        dec_q.delete();
        exp_q.delete();
        break;
      end
      if (!to) begin
        repeat ($urandom_range(0, 5)) step();
        pay_ack = 1'b1;
        step();
        pay_ack = 1'b0;
        check("valid_after_pay", bill_valid, 0);
      end else begin
        n = 0;
        while (!timeout_flag && n < 40) begin step(); n++; end
        check("timeout_cycles", n, TIMEOUT);
        check("valid_after_timeout", bill_valid, 0);
        step();
        check("timeout_pulse_width", timeout_flag, 0);
      end
    end
    check("pending_drained", pending, 0);
    check("pending_cnt_drained", pending_cnt, 0);
  endtask

  task automatic random_round();
    logic [7:0] set, occ;
    int         dur;
    int         st[N];
    set = 8'($urandom_range(1, 255));
    dur = $urandom_range(1, 20);
    for (int i = 0; i < N; i++) st[i] = $urandom_range(0, dur - 1);
    for (int c = 0; c < dur; c++) begin
      occ = '0;
      for (int i = 0; i < N; i++) if (set[i] && c >= st[i]) occ[i] = 1'b1;
      cycle(occ, $urandom_range(0, 23));
    end
    cycle(8'h00, $urandom_range(0, 23));
    plan_bills(1);
    serve_bills();
  endtask

  // Monitor: compare each newly presented bill against the scoreboard and check it is held.
  bill_t       cur;
  logic [21:0] held;
  logic        prev_valid = 1'b0;

  always @(negedge time_clk) begin
    if (rst && power && bill_valid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bill_slot", bill_slot, 99);
        end else begin
          cur = exp_q.pop_front();
          check("bill_slot", bill_slot, cur.slot);
          check("bill_day", bill_day, cur.day);
          check("bill_night", bill_night, cur.night);
          check("bill_fee", bill_fee, cur.fee);
          check("pending_cnt_at_bill", pending_cnt, cur.cnt);
        end
        held = {bill_slot, bill_day, bill_night, bill_fee};
      end else begin
        check("bill_held", {bill_slot, bill_day, bill_night, bill_fee}, held);
      end
    end
    prev_valid = bill_valid && rst && power;
  end

  initial begin
    bit ok;
    model_clear();
    repeat (3) step();
    check("rst_valid", bill_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_pending_cnt", pending_cnt, 0);
    check("rst_timeout", timeout_flag, 0);
    check("rst_fee", bill_fee, 0);
    rst = 1'b1;
    step();
    power = 1'b1;
    step();

    // Three simultaneous departures with pointer at 0: bills 1, 3, 6.
    cycle(8'h08, 3);
    repeat (2) cycle(8'h4A, 3);
    cycle(8'h4A, 12);
    cycle(8'h00, 12);
    plan_bills(0);
    serve_bills();

    // Slot 2, 5 day ticks; latency and pay_ack ignored outside PRESENT.
    repeat (5) cycle(8'h04, 10);
    cycle(8'h00, 10);
    plan_bills(0);
    check("lat_e0", bill_valid, 0);
    pay_ack = 1'b1;
    step();
    check("lat_e1", bill_valid, 0);
    step();
    pay_ack = 1'b0;
    check("lat_e2", bill_valid, 1);
    check("pending_slot2", pending, 8'h04);
    serve_bills();

    // Slots 0 and 4 pending with pointer 3: slot 4 times out, slot 0 billed, slot 4 re-billed.
    cycle(8'h01, 10);
    repeat (2) cycle(8'h11, 10);
    repeat (2) cycle(8'h11, 2);
    cycle(8'h00, 2);
    plan_bills(2);
    serve_bills();

    // Day/night boundaries.
    repeat (3) cycle(8'h20, 23);
    repeat (2) cycle(8'h20, 6);
    cycle(8'h00, 6);
    plan_bills(0);
    serve_bills();
    repeat (2) cycle(8'h40, 22);
    repeat (3) cycle(8'h40, 5);
    cycle(8'h00, 5);
    plan_bills(0);
    serve_bills();

    // Long stays: slot 0 for 40 day ticks, slot 1 saturating day, slot 7 saturating night.
    repeat (30) cycle(8'h02, 12);
    repeat (40) cycle(8'h03, 12);
    cycle(8'h00, 12);
    plan_bills(0);
    serve_bills();
    repeat (35) cycle(8'h80, 0);
    cycle(8'h00, 0);
    plan_bills(0);
    serve_bills();

    // Masked slot 7 is ignored entirely.
    slot_mask = 8'h7F;
    repeat (4) cycle(8'hC0, 8);
    cycle(8'h00, 8);
    plan_bills(0);
    serve_bills();
    slot_mask = 8'hFF;

    // Re-entry and mask drop while pending.
    repeat (3) cycle(8'h04, 10);
    cycle(8'h00, 10);
    exp_q.push_back('{2, snap_d[2], snap_n[2], fee_of(snap_d[2], snap_n[2]), 1});
    wait_valid(ok);
    check("reentry_bill_arrives", ok, 1);
    repeat (4) cycle(8'h04, 10);
    check("reentry_pending", pending, 8'h04);
    slot_mask = 8'hFB;
    cycle(8'h04, 10);
    check("mask_keeps_pending", pending, 8'h04);
    slot_mask = 8'hFF;
    cycle(8'h00, 10);
    cycle(8'h04, 10);
    pay_ack = 1'b1;
    cycle(8'h04, 10);
    pay_ack = 1'b0;
    mpend[2] = 1'b0;
    m_ptr = 3;
    check("reentry_paid", pending, 0);
    repeat (3) cycle(8'h04, 10);
    cycle(8'h00, 10);
    plan_bills(0);
    serve_bills();

    // Power drop mid-PRESENT while slot 5 is still occupied.
    repeat (2) cycle(8'h28, 10);
    cycle(8'h20, 10);
    exp_q.push_back('{3, snap_d[3], snap_n[3], fee_of(snap_d[3], snap_n[3]), 1});
    mpend = '0;
    repeat (3) cycle(8'h20, 10);
    check("present_before_power", bill_valid, 1);
    power = 1'b0;
    cycle(8'h20, 10);
    check("power_valid", bill_valid, 0);
    check("power_pending", pending, 0);
    check("power_pending_cnt", pending_cnt, 0);
    power = 1'b1;
    repeat (4) cycle(8'h20, 22);
    cycle(8'h00, 22);
    plan_bills(0);
    serve_bills();

    for (int r = 0; r < 10; r++) random_round();

    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
